// File: rtl/reg_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback_pkg
// Description : Shared register-file constants, writeback request type and
//               the busy-mask helper used by the writeback block.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_writeback_pkg;

    localparam int c_NUM_REGS = 32;
    localparam int c_ADDR_W   = 5;
    localparam int c_DATA_W   = 32;

    typedef struct packed {
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] data;
    } wb_req_t;

    // One-hot register mask; x0 is hard-wired and never reported busy.
    function automatic logic [c_NUM_REGS-1:0] reg_mask(input logic [c_ADDR_W-1:0] addr);
        logic [c_NUM_REGS-1:0] m;
        m       = '0;
        m[addr] = 1'b1;
        m[0]    = 1'b0;
        return m;
    endfunction

endpackage : reg_writeback_pkg
`default_nettype wire

// File: rtl/reg_writeback_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Slow-source writeback queue with per-entry valid/address taps
//               for the pending-write mask.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import reg_writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_push,
    input  logic [c_ADDR_W-1:0]       i_push_addr,
    input  logic [c_DATA_W-1:0]       i_push_data,
    input  logic                      i_pop,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [c_ADDR_W-1:0]       o_head_addr,
    output logic [c_DATA_W-1:0]       o_head_data,
    output logic [DEPTH-1:0]          o_ent_valid,
    output logic [DEPTH*c_ADDR_W-1:0] o_ent_addr
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t              r_mem [DEPTH];
    logic [DEPTH-1:0]     r_vld;
    logic [c_PTR_W-1:0]   r_wr;
    logic [c_PTR_W-1:0]   r_rd;
    logic                 w_push;
    logic                 w_pop;

    assign o_full  = &r_vld;
    assign o_empty = ~|r_vld;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
        end else begin
            if (w_push) begin
                r_vld[r_wr] <= 1'b1;
                r_wr        <= r_wr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_vld[r_rd] <= 1'b0;
                r_rd        <= r_rd + c_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= '{addr: i_push_addr, data: i_push_data};
        end
    end

    assign o_head_addr = r_mem[r_rd].addr;
    assign o_head_data = r_mem[r_rd].data;
    assign o_ent_valid = r_vld;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            assign o_ent_addr[gi*c_ADDR_W +: c_ADDR_W] = r_mem[gi].addr;
        end
    endgenerate

endmodule : wb_fifo
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback
// Description : Two-source register-file writeback arbiter; fast requests win,
//               slow requests queue. REG_WB_STARVE_GUARD_EN adds a forced drain.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fast_valid,
    output logic                  fast_ready,
    input  logic [c_ADDR_W-1:0]   fast_addr,
    input  logic [c_DATA_W-1:0]   fast_data,
    input  logic                  slow_valid,
    output logic                  slow_ready,
    input  logic [c_ADDR_W-1:0]   slow_addr,
    input  logic [c_DATA_W-1:0]   slow_data,
    output logic                  wb_we,
    output logic [c_ADDR_W-1:0]   wb_addr,
    output logic [c_DATA_W-1:0]   wb_data,
    output logic [c_NUM_REGS-1:0] busy
);

    logic                           w_full;
    logic                           w_empty;
    logic [c_ADDR_W-1:0]            w_head_addr;
    logic [c_DATA_W-1:0]            w_head_data;
    logic [FIFO_DEPTH-1:0]          w_ent_valid;
    logic [FIFO_DEPTH*c_ADDR_W-1:0] w_ent_addr;
    logic                           w_fast_acc;
    logic                           w_pop;
    logic                           w_sel_vld;
    wb_req_t                        w_sel;
    logic [c_NUM_REGS-1:0]          w_busy;
    logic                           r_we;
    logic [c_ADDR_W-1:0]            r_addr;
    logic [c_DATA_W-1:0]            r_data;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (slow_valid),
        .i_push_addr (slow_addr),
        .i_push_data (slow_data),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_ent_valid (w_ent_valid),
        .o_ent_addr  (w_ent_addr)
    );

    assign slow_ready = ~w_full;
    assign w_fast_acc = fast_valid & fast_ready;
    assign w_pop      = ~w_fast_acc & ~w_empty;
    assign w_sel_vld  = w_fast_acc | w_pop;

    always_comb begin
        w_sel = '{addr: w_head_addr, data: w_head_data};
        if (w_fast_acc) begin
            w_sel = '{addr: fast_addr, data: fast_data};
        end
    end

`ifdef REG_WB_STARVE_GUARD_EN
    localparam logic [7:0] c_STARVE_LIM = 8'(STARVE_LIMIT);

    logic [7:0] r_starve_cnt;

    // Reaching the limit blocks the fast port, so the head must pop next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_empty || w_pop) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    assign fast_ready = (r_starve_cnt != c_STARVE_LIM);
`else
    logic w_unused_limit;
    assign w_unused_limit = ^STARVE_LIMIT;
    assign fast_ready     = 1'b1;
`endif

    // Writes to x0 are consumed but leave the visible address/data untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_sel_vld && (w_sel.addr != '0);
            if (w_sel_vld && (w_sel.addr != '0)) begin
                r_addr <= w_sel.addr;
                r_data <= w_sel.data;
            end
        end
    end

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_ent_valid[i]) begin
                w_busy = w_busy | reg_mask(w_ent_addr[i*c_ADDR_W +: c_ADDR_W]);
            end
        end
        if (r_we) begin
            w_busy = w_busy | reg_mask(r_addr);
        end
    end

    assign wb_we   = r_we;
    assign wb_addr = r_addr;
    assign wb_data = r_data;
    assign busy    = w_busy;

endmodule : reg_writeback
`default_nettype wire
